// File: rtl/alu_serial_pkg.sv
// Shared operation codes, FSM encoding and helpers for the bit-serial ALU sequencer.
package alu_serial_pkg;

   localparam logic [2:0] OP_MOV  = 3'b000;
   localparam logic [2:0] OP_NOT  = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Operations whose carry chain is meaningful; logic ops force carry to 0.
   function automatic logic is_arith(input logic [2:0] sel);
      return (sel == OP_ADD) || (sel == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_slice_1b.sv
// Combinational 1-bit ALU slice; SUB inverts b here so the controller only seeds carry-in.
module alu_slice_1b
   import alu_serial_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       c_in,
   input  logic [2:0] sel,
   output logic       out,
   output logic       c_out
);

   logic b_eff;

   assign b_eff = (sel == OP_SUB) ? ~b : b;

   always_comb begin
      out   = a;
      c_out = 1'b0;
      case (sel)
         OP_NOT:  out = ~a;
         OP_NAND: out = ~(a & b);
         OP_NOR:  out = ~(a | b);
         OP_ADD,
         OP_SUB: begin
            out   = a ^ b_eff ^ c_in;
            c_out = (a & b_eff) | (c_in & (a ^ b_eff));
         end
         default: out = a;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one slice, LSB first, valid/ready on both sides.
// Optional res_zero/res_ovf outputs are built when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_ctrl
   import alu_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [2:0]       op_sel,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_cout,
   output logic             busy
`ifdef ALU_SERIAL_FLAGS_EN
   ,
   output logic             res_zero,
   output logic             res_ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [2:0]       sel_q;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic             slice_out;
   logic             slice_cout;

   alu_slice_1b u_slice (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c_in  (carry_q),
      .sel   (sel_q),
      .out   (slice_out),
      .c_out (slice_cout)
   );

   assign res_data = res_sh;
   assign res_cout = carry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_ready  <= 1'b1;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         res_sh    <= '0;
         sel_q     <= OP_MOV;
         cnt       <= '0;
         carry_q   <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
         res_zero  <= 1'b0;
         res_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (op_valid) begin
                  a_sh     <= op_a;
                  b_sh     <= op_b;
                  sel_q    <= op_sel;
                  cnt      <= CNT_W'(WIDTH - 1);
                  carry_q  <= (op_sel == OP_SUB);
                  state    <= ST_RUN;
                  op_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_RUN: begin
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               res_sh  <= {slice_out, res_sh[WIDTH-1:1]};
               carry_q <= is_arith(sel_q) ? slice_cout : 1'b0;
               cnt     <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state     <= ST_DONE;
                  res_valid <= 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
                  // carry_q is the carry into the MSB on this final edge
                  res_zero  <= ({slice_out, res_sh[WIDTH-1:1]} == '0);
                  res_ovf   <= is_arith(sel_q) & (carry_q ^ slice_cout);
`endif
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  state     <= ST_IDLE;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  op_ready  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed + random scoreboard bench for alu_serial_ctrl (WIDTH=8).
// Flag outputs are checked when ALU_SERIAL_FLAGS_EN is defined.
module tb_alu_serial_ctrl;

   localparam int unsigned W = 8;

   localparam logic [2:0] MOV  = 3'b000;
   localparam logic [2:0] NOTA = 3'b001;
   localparam logic [2:0] NAND = 3'b011;
   localparam logic [2:0] NOR  = 3'b100;
   localparam logic [2:0] ADD  = 3'b110;
   localparam logic [2:0] SUB  = 3'b101;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         op_valid = 1'b0;
   logic         op_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic [2:0]   op_sel = 3'b000;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [W-1:0] res_data;
   logic         res_cout;
   logic         busy;
`ifdef ALU_SERIAL_FLAGS_EN
   logic         res_zero;
   logic         res_ovf;
`endif

   always #5 clk = ~clk;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_sel    (op_sel),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_cout  (res_cout),
      .busy      (busy)
`ifdef ALU_SERIAL_FLAGS_EN
      ,
      .res_zero  (res_zero),
      .res_ovf   (res_ovf)
`endif
   );

   typedef struct {
      logic [W-1:0] d;
      logic         c;
      logic         z;
      logic         v;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] sel);
      exp_t         e;
      logic [W:0]   s;
      e.d = a;
      e.c = 1'b0;
      e.v = 1'b0;
      case (sel)
         NOTA: e.d = ~a;
         NAND: e.d = ~(a & b);
         NOR:  e.d = ~(a | b);
         ADD: begin
            s   = {1'b0, a} + {1'b0, b};
            e.d = s[W-1:0];
            e.c = s[W];
            e.v = (a[W-1] == b[W-1]) && (e.d[W-1] != a[W-1]);
         end
         SUB: begin
            s   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            e.d = s[W-1:0];
            e.c = s[W];
            e.v = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
         end
         default: e.d = a;
      endcase
      e.z = (e.d == '0);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Enters and leaves on a falling edge; returns one cycle after the accept edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
      int n = 0;
      while (!op_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("issue_ready", 32'(op_ready), 32'd1);
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      op_sel   = sel;
      sb.push_back(model(a, b, sel));
      @(negedge clk);
      op_valid = 1'b0;
      check("busy_after_accept", {30'd0, op_ready, busy}, 32'b01);
   endtask

   // Counts cycles until res_valid; optionally disturbs inputs while the op runs.
   task automatic wait_valid(output int lat, input bit scramble);
      lat = 0;
      while (!res_valid && lat < 40) begin
         if (scramble) begin
            op_valid = lat[0];
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            op_sel   = 3'($urandom);
            check("ready_low_run", 32'(op_ready), 32'd0);
         end
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(W));
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb[0];
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_data"}, 32'(res_data), 32'(e.d));
      check({tag, "_cout"}, 32'(res_cout), 32'(e.c));
`ifdef ALU_SERIAL_FLAGS_EN
      check({tag, "_zero"}, 32'(res_zero), 32'(e.z));
      check({tag, "_ovf"}, 32'(res_ovf), 32'(e.v));
`endif
   endtask

   task automatic retire(input string tag);
      res_ready = 1'b1;
      if (sb.size() != 0) void'(sb.pop_front());
      @(negedge clk);
      check({tag, "_after_retire"}, {29'd0, res_valid, op_ready, busy}, 32'b010);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] sel);
      int lat;
      issue(a, b, sel);
      wait_valid(lat, 1'b0);
      check_result(tag);
      retire(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_op_ready", 32'(op_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
      check("rst_res_cout", 32'(res_cout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_SERIAL_FLAGS_EN
      check("rst_flags", {30'd0, res_zero, res_ovf}, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Directed ops, res_ready held high
      run_op("add_3c_0f", 8'h3C, 8'h0F, ADD);
      check("add_3c_0f_literal", 32'(model(8'h3C, 8'h0F, ADD).d), 32'h4B);
      run_op("sub_07_05", 8'h07, 8'h05, SUB);
      run_op("sub_05_07", 8'h05, 8'h07, SUB);
      run_op("nand_f0_cc", 8'hF0, 8'hCC, NAND);
      run_op("sel111_a5", 8'hA5, 8'h3C, 3'b111);
      run_op("sel010_5a", 8'h5A, 8'hFF, 3'b010);
      run_op("not_a5", 8'hA5, 8'h00, NOTA);
      run_op("nor_0f_30", 8'h0F, 8'h30, NOR);
      run_op("mov_c3", 8'hC3, 8'h11, MOV);
      run_op("add_7f_01", 8'h7F, 8'h01, ADD);
      run_op("sub_10_10", 8'h10, 8'h10, SUB);
      run_op("sub_80_01", 8'h80, 8'h01, SUB);

      // Backpressure: result held 5 cycles, op_valid noise ignored in RUN and DONE
      res_ready = 1'b0;
      issue(8'h9A, 8'h47, ADD);
      wait_valid(lat, 1'b1);
      repeat (5) begin
         check_result("hold");
         op_valid = 1'b1;
         op_a     = W'($urandom);
         check("ready_low_done", 32'(op_ready), 32'd0);
         check("busy_done", 32'(busy), 32'd1);
         @(negedge clk);
      end
      op_valid = 1'b0;
      check_result("hold_end");
      retire("hold");

      // Retire and new request in the same cycle: request is not taken
      issue(8'h21, 8'h13, SUB);
      wait_valid(lat, 1'b0);
      check_result("overlap");
      op_valid = 1'b1;
      op_a     = 8'h55;
      op_sel   = ADD;
      void'(sb.pop_front());
      @(negedge clk);
      op_valid = 1'b0;
      check("overlap_retired", {29'd0, res_valid, op_ready, busy}, 32'b010);
      @(negedge clk);
      check("overlap_not_taken", {30'd0, op_ready, busy}, 32'b10);

      // Reset in RUN cycle 3
      issue(8'h12, 8'h34, ADD);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      check("rst_run_state", {29'd0, op_ready, res_valid, busy}, 32'b100);
      check("rst_run_data", 32'(res_data), 32'd0);
      check("rst_run_cout", 32'(res_cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_op("add_ff_01", 8'hFF, 8'h01, ADD);

      // Reset while a result is waiting in DONE
      res_ready = 1'b0;
      issue(8'h44, 8'h22, NOR);
      wait_valid(lat, 1'b0);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      check("rst_done_state", {29'd0, op_ready, res_valid, busy}, 32'b100);
      check("rst_done_data", 32'(res_data), 32'd0);
      rst = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);

      // Random ops
      for (int i = 0; i < 10; i++) begin
         logic [2:0] rs;
         rs = 3'($urandom);
         run_op("rand", W'($urandom), W'($urandom), rs);
      end

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Sequencer that runs a WIDTH-bit ALU operation bit-serially through a single 1-bit ALU slice, LSB first, one bit per clock. It accepts an operation through a valid/ready handshake, shifts operands through the slice while holding the inter-bit carry in a flip-flop, and presents the assembled result with a valid/ready handshake. It sits between an instruction-issue stage and the register write-back path, trading latency for area relative to a parallel N-slice ALU.

## Interface
- WIDTH, 8, operand/result width in bits; minimum 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- op_valid  in  1  request present.
- op_ready  out  1  controller can accept a request; high only in IDLE.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_sel  in  3  operation: 000 MOV (out=a), 001 NOT (~a), 011 NAND, 100 NOR, 110 ADD, 101 SUB (a-b); 010 and 111 execute as MOV.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer takes result.
- res_data  out  WIDTH  result.
- res_cout  out  1  final carry of ADD/SUB (SUB: 1 = no borrow); 0 for logic ops.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states IDLE, RUN, DONE; reset enters IDLE.
- IDLE: op_ready=1. On op_valid: latch op_a, op_b into shift registers, latch op_sel, load bit counter with WIDTH-1, load carry with 1 for SUB and 0 otherwise; go RUN.
- RUN: slice sees a_sh[0], b_sh[0], latched sel, carry_q. Each cycle: shift a_sh, b_sh right; shift slice output into res_sh at MSB; carry_q <= slice c_out for ADD/SUB, else 0; decrement counter. When counter is 0 on that edge, go DONE.
- SUB inverts b inside the slice (sel 101); controller only provides the initial carry of 1.
- DONE: res_valid=1, res_data=res_sh, res_cout=carry_q; held stable until res_valid && res_ready, then IDLE.
- op_valid outside IDLE ignored (op_ready=0); input changes during RUN have no effect.
- DONE with res_ready and op_valid in the same cycle: result retired, new op not accepted; accepted earliest the following cycle.
- rst at any point (including mid-RUN, or DONE with res_valid high): next cycle IDLE, in-flight op discarded.
- Reset values: op_ready=1, res_valid=0, res_data=0, res_cout=0, busy=0.

## Timing
- Accept edge T0 (op_valid && op_ready). Bits 0..WIDTH-1 computed on edges T1..TWIDTH. res_valid high in the cycle after edge TWIDTH: WIDTH cycles from the accept edge.
- Throughput with res_ready tied high: one op per WIDTH+2 cycles (IDLE, WIDTH RUN, DONE).
- All outputs registered or decoded from state only; no combinational path from op_valid/res_ready to any output.

## Configuration
- ALU_SERIAL_FLAGS_EN defined: adds outputs res_zero (res_data==0) and res_ovf (signed overflow of ADD/SUB: carry into MSB xor carry out of MSB, captured on the last RUN edge; 0 for logic ops). Both are valid with res_valid, reset to 0.
- Undefined: the ports and their logic are absent; behaviour otherwise identical.

## Structure
- Package alu_serial_pkg: op_sel localparams (OP_MOV, OP_NOT, OP_NAND, OP_NOR, OP_ADD, OP_SUB) and FSM state typedef/encoding.
- One sub-module alu_slice_1b: combinational 1-bit slice (out, c_out from a, b, sel, c_in) implementing the op_sel table above; the controller instantiates exactly one.

## Test plan
- WIDTH=8, ADD 0x3C+0x0F, res_ready=1 -> res_valid exactly 8 cycles after accept, res_data=0x4B, res_cout=0; next op_ready after 2 more cycles.
- SUB 0x07-0x05 -> 0x02, res_cout=1; SUB 0x05-0x07 -> 0xFE, res_cout=0.
- NAND 0xF0,0xCC -> 0x3F, res_cout=0; op_sel=111 with a=0xA5 -> 0xA5.
- res_ready held low 5 cycles in DONE -> res_valid, res_data stable throughout; op_valid pulses during RUN/DONE ignored, op_ready=0.
- rst asserted in RUN cycle 3 -> next cycle IDLE, res_valid=0, res_data=0, op_ready=1; subsequent ADD 0xFF+0x01 -> 0x00, res_cout=1.
- With ALU_SERIAL_FLAGS_EN: ADD 0x7F+0x01 -> 0x80, res_ovf=1, res_zero=0; SUB 0x10-0x10 -> res_zero=1, res_ovf=0.
